// File: rtl/dso_pkg.sv
// Shared definitions for the DSO capture readout path: FSM state encoding
// and the frame counter width.
package dso_pkg;

    localparam int FRAME_CNT_W = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LATCH = 3'd1,
        HDR   = 3'd2,
        READ  = 3'd3,
        DRAIN = 3'd4
    } state_e;

endpackage

// File: rtl/skid_fifo2.sv
// Two-entry fall-through FIFO. When empty, an incoming word is presented on
// the output in the same cycle and is only stored if the consumer stalls.
// The writer is expected to respect the occupancy count: there is no
// back-pressure on the input side.
module skid_fifo2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    input  logic         out_ready,
    output logic [1:0]   count
);

    logic [1:0]   cnt_q, cnt_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic         wr_ptr_q, wr_ptr_d;
    logic [W-1:0] mem_q [2];
    logic         empty, store, pop_mem;

    // Head selection, bypass decision and pointer/occupancy update
    always_comb begin
        empty     = (cnt_q == 2'd0);
        out_valid = !empty || in_valid;
        out_data  = empty ? in_data : mem_q[rd_ptr_q];
        store     = in_valid && !(empty && out_ready);
        pop_mem   = !empty && out_ready;
        cnt_d     = cnt_q + {1'b0, store} - {1'b0, pop_mem};
        wr_ptr_d  = wr_ptr_q ^ store;
        rd_ptr_d  = rd_ptr_q ^ pop_mem;
        count     = cnt_q;
    end

    // Occupancy and pointers; reset empties the FIFO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= 2'd0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    // Storage; contents are don't-care while the entry is not counted
    always_ff @(posedge clk) begin
        if (store) mem_q[wr_ptr_q] <= in_data;
    end

endmodule

// File: rtl/capture_readout_ctrl.sv
// Readout sequencer for the ping-pong capture buffer: takes a completed bank
// from the ADC driver, reads it out of RAM starting pretrig samples before
// the trigger, and streams it through a 2-entry skid FIFO.
// Optional: READOUT_HEADER_EN prepends one header word (frame count).
module capture_readout_ctrl
    import dso_pkg::*;
#(
    parameter int DEPTH = 11,
    parameter int ADC_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   arm,
    input  logic [DEPTH-1:0]       pretrig,
    input  logic                   acq_valid,
    output logic                   acq_ready,
    input  logic [DEPTH:0]         trig_addr,
    output logic                   rd_en,
    output logic [DEPTH:0]         rd_addr,
    input  logic [ADC_W-1:0]       rd_data,
    output logic [ADC_W-1:0]       m_data,
    output logic                   m_valid,
    output logic                   m_last,
    input  logic                   m_ready,
    output logic                   busy,
    output logic [FRAME_CNT_W-1:0] frame_cnt
);

    localparam logic [DEPTH:0] LAST_CNT = {1'b0, {DEPTH{1'b1}}};

    state_e                 state_q, state_d;
    logic                   bank_q, bank_d;
    logic [DEPTH-1:0]       base_q, base_d;
    logic [DEPTH:0]         cnt_q, cnt_d;
    logic                   inflight_q, inflight_d;
    logic                   last_inflight_q, last_inflight_d;
    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;

    logic                   issue, drained;
    logic [1:0]             fifo_cnt;
    logic                   push_valid;
    logic [ADC_W:0]         push_data, head_data;

    // Read credit: a FIFO slot must be free for every read in the pipe
    always_comb begin
        issue   = (state_q == READ) &&
                  (({1'b0, fifo_cnt} + {2'b0, inflight_q}) < 3'd2);
        drained = (fifo_cnt == 2'd0) && !inflight_q;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (acq_valid && arm) state_d = LATCH;
`ifdef READOUT_HEADER_EN
            LATCH: state_d = HDR;
`else
            LATCH: state_d = READ;
`endif
            HDR:   state_d = READ;
            READ:  if (issue && (cnt_q == LAST_CNT)) state_d = DRAIN;
            DRAIN: if (drained) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs and RAM request
    always_comb begin
        acq_ready = (state_q == IDLE) && arm;
        busy      = (state_q != IDLE);
        rd_en     = issue;
        rd_addr   = {bank_q, base_q + cnt_q[DEPTH-1:0]};
        frame_cnt = frame_cnt_q;
    end

    // Frame geometry, read counter, in-flight tracking and frame count
    always_comb begin
        bank_d          = bank_q;
        base_d          = base_q;
        cnt_d           = cnt_q;
        frame_cnt_d     = frame_cnt_q;
        inflight_d      = issue;
        last_inflight_d = issue && (cnt_q == LAST_CNT);
        if (state_q == LATCH) begin
            bank_d = trig_addr[DEPTH];
            base_d = trig_addr[DEPTH-1:0] - pretrig;
            cnt_d  = '0;
        end
        if (issue) cnt_d = cnt_q + 1'b1;
        if ((state_q == DRAIN) && drained) frame_cnt_d = frame_cnt_q + 1'b1;
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_q          <= 1'b0;
            base_q          <= '0;
            cnt_q           <= '0;
            inflight_q      <= 1'b0;
            last_inflight_q <= 1'b0;
            frame_cnt_q     <= '0;
        end else begin
            bank_q          <= bank_d;
            base_q          <= base_d;
            cnt_q           <= cnt_d;
            inflight_q      <= inflight_d;
            last_inflight_q <= last_inflight_d;
            frame_cnt_q     <= frame_cnt_d;
        end
    end

    // FIFO write side: returning RAM data tagged with its last flag, or the header
    always_comb begin
`ifdef READOUT_HEADER_EN
        push_valid = inflight_q || (state_q == HDR);
        push_data  = (state_q == HDR) ? {1'b0, ADC_W'(frame_cnt_q)}
                                      : {last_inflight_q, rd_data};
`else
        push_valid = inflight_q;
        push_data  = {last_inflight_q, rd_data};
`endif
    end

    skid_fifo2 #(.W(ADC_W + 1)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (push_valid),
        .in_data   (push_data),
        .out_valid (m_valid),
        .out_data  (head_data),
        .out_ready (m_ready),
        .count     (fifo_cnt)
    );

    // Stream outputs
    always_comb begin
        m_data = head_data[ADC_W-1:0];
        m_last = m_valid && head_data[ADC_W];
    end

endmodule

// File: tb/tb_capture_readout_ctrl.sv
// Bench for capture_readout_ctrl at DEPTH=4, ADC_W=8 with a 1-cycle RAM whose
// data is the low byte of the read address. Honours READOUT_HEADER_EN.
module tb_capture_readout_ctrl;

    localparam int DEPTH = 4;
    localparam int ADC_W = 8;
    localparam int NS    = 16;
`ifdef READOUT_HEADER_EN
    localparam int HDR_WORDS = 1;
`else
    localparam int HDR_WORDS = 0;
`endif
    localparam int NW = NS + HDR_WORDS;

    logic             clk = 1'b0;
    logic             rst_n, arm, acq_valid, acq_ready, rd_en;
    logic             m_valid, m_last, m_ready, busy;
    logic [DEPTH-1:0] pretrig;
    logic [DEPTH:0]   trig_addr, rd_addr;
    logic [ADC_W-1:0] rd_data, m_data;
    logic [7:0]       frame_cnt;

    int vectors = 0, miscompares = 0, cyc = 0;
    bit rnd_ready = 0;
    logic [8:0] words[$];
    int hs_cyc, first_rd, first_mv;
    logic [DEPTH:0] first_rd_addr;
    bit prev_stall = 0;
    logic [ADC_W-1:0] prev_data;
    int fc_model = 0;
    int exp_bank, exp_trig, exp_pt;

    capture_readout_ctrl #(.DEPTH(DEPTH), .ADC_W(ADC_W)) dut (
        .clk(clk), .rst_n(rst_n), .arm(arm), .pretrig(pretrig),
        .acq_valid(acq_valid), .acq_ready(acq_ready), .trig_addr(trig_addr),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
        .busy(busy), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM model
    always @(posedge clk) if (rd_en) rd_data <= ADC_W'(rd_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected RAM address of sample i of the current frame
    function automatic int model_addr(input int i);
        return exp_bank * NS + (((exp_trig - exp_pt + i) % NS) + NS) % NS;
    endfunction

    // Stream/port monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", m_valid, 1);
                chk("stall_data", m_data, prev_data);
            end
            if (busy) chk("ready_while_busy", acq_ready, 0);
            if (rd_en && first_rd < 0) begin
                first_rd = cyc;
                first_rd_addr = rd_addr;
            end
            if (m_valid && first_mv < 0) first_mv = cyc;
            if (m_valid && m_ready) words.push_back({m_last, m_data});
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
        end
    end

    // Stream back-pressure driver
    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            m_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic start_frame(input int b, input int trig, input int pt, input bit hold);
        bit got = 0;
        @(posedge clk); #1;
        pretrig   = DEPTH'(pt);
        trig_addr = (DEPTH+1)'($urandom);
        acq_valid = 1'b1;
        exp_bank = b; exp_trig = trig; exp_pt = pt;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (acq_ready) begin got = 1; break; end
        end
        chk("handshake", got, 1);
        hs_cyc = cyc; first_rd = -1; first_mv = -1;
        words.delete();
        @(posedge clk); #1;
        trig_addr = {1'(b), DEPTH'(trig)};
        acq_valid = hold;
        @(posedge clk); #1;
        pretrig = DEPTH'($urandom);
    endtask

    task automatic finish_frame();
        int hdr_fc = fc_model;
        for (int i = 0; i < 4000 && words.size() < NW; i++) @(negedge clk);
        chk("word_count", words.size(), NW);
        for (int i = 0; i < 10 && busy; i++) @(negedge clk);
        chk("idle_after_drain", busy, 0);
        fc_model = (fc_model + 1) % 256;
        chk("frame_cnt", frame_cnt, fc_model);
        chk("first_rd_lat", first_rd - hs_cyc, 2 + HDR_WORDS);
        chk("first_rd_addr", first_rd_addr, model_addr(0));
        chk("first_mv_lat", first_mv - hs_cyc, (HDR_WORDS != 0) ? 2 : 3);
        for (int i = 0; i < NW && i < words.size(); i++) begin
            if (i < HDR_WORDS) begin
                chk("header", words[i], {1'b0, 8'(hdr_fc)});
            end else begin
                chk("sample", words[i],
                    {(i - HDR_WORDS == NS - 1), 8'(model_addr(i - HDR_WORDS))});
            end
        end
    endtask

    task automatic run_frame(input int b, input int trig, input int pt, input bit hold);
        start_frame(b, trig, pt, hold);
        finish_frame();
    endtask

    initial begin
        arm = 0; acq_valid = 0; pretrig = '0; trig_addr = '0; rst_n = 1;
        #2 rst_n = 0;
        repeat (3) @(posedge clk); #1;
        chk("rst_acq_ready", acq_ready, 0);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        rst_n = 1; arm = 1;

        // Directed frames with the stream always ready
        run_frame(1, 6, 4, 0);
        run_frame(0, 1, 3, 0);

        // Random back-pressure, wrap boundaries and random geometry
        rnd_ready = 1;
        run_frame(1, 6, 4, 0);
        run_frame(0, 0, 5, 0);
        run_frame(1, 9, 0, 0);
        for (int k = 0; k < 3; k++)
            run_frame($urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 15), 0);

        // acq_valid held, arm dropped mid-frame
        fork
            run_frame(0, 9, 2, 1);
            begin repeat (8) @(posedge clk); #1 arm = 0; end
        join
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("disarmed_ready", acq_ready, 0);
            chk("disarmed_busy", busy, 0);
        end
        @(posedge clk); #1;
        acq_valid = 0; arm = 1;

        // Reset in the middle of a frame
        rnd_ready = 0;
        start_frame(1, 3, 1, 0);
        for (int i = 0; i < 200 && words.size() < 7; i++) @(negedge clk);
        chk("pre_reset_words", words.size(), 7);
        #1 rst_n = 0;
        #1;
        chk("midrst_m_valid", m_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_frame_cnt", frame_cnt, 0);
        fc_model = 0;
        @(posedge clk); #1 rst_n = 1;
        run_frame(0, 12, 7, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
